// File: rtl/gpio_shift_rx_pkg.sv
// Shared types for the GPIO serial shift receiver: FSM state encoding,
// bit-order selector and the default partial-word timeout.
package gpio_shift_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_e;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } bit_order_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd4096;

endpackage

// File: rtl/gpio_shift_rx_sync.sv
// N-stage pad synchronizer with a rising-edge strobe on the synchronized level.
module gpio_shift_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pad level through the chain and remember the last synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{1'b0}};
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/gpio_shift_rx.sv
// Serial shift receiver for externally clocked GPIO bit streams.
// Optional partial-word timeout is built when GPIO_SHIFT_RX_TIMEOUT_EN is defined.
module gpio_shift_rx
  import gpio_shift_rx_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk_i,
  input  logic                       sdata_i,
  input  logic                       frame_i,
  input  logic                       lsb_first_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       overrun_o,
  input  logic                       clear_i,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt_o,
  output logic                       timeout_o
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SHIFT  = ST_SHIFT;
  localparam logic [1:0] S_COMMIT = ST_COMMIT;

  logic             shift;
  logic             data_sync;
  logic             frame_sync;
  logic             sclk_level_unused;
  logic             data_rise_unused;
  logic             frame_rise_unused;
  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  bit_order_e       order;
  logic             tmo_hit;
  logic             commit;
  logic             load;

  // Equal-depth synchronizers keep each data bit aligned with its clock edge.
  gpio_shift_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk_i), .q(sclk_level_unused), .rise(shift)
  );
  gpio_shift_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(sdata_i), .q(data_sync), .rise(data_rise_unused)
  );
  gpio_shift_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clk(clk), .rst_n(rst_n), .d(frame_i), .q(frame_sync), .rise(frame_rise_unused)
  );

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic d,
                                                input bit_order_e ord);
    if (ord == ORDER_LSB_FIRST) begin
      shift_in = {d, cur[WIDTH-1:1]};
    end else begin
      shift_in = {cur[WIDTH-2:0], d};
    end
  endfunction

`ifdef GPIO_SHIFT_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);
  localparam logic [TW-1:0] TMO_ZERO = TW'(0);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_SHIFT) && frame_sync && !shift &&
                   (cnt != CNT_ZERO) && (tmo_cnt == TMO_LAST);

  // Idle-cycle counter, restarted by every strobe and whenever no partial word is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= TMO_ZERO;
    end else if ((state != S_SHIFT) || (cnt == CNT_ZERO) || shift || tmo_hit) begin
      tmo_cnt <= TMO_ZERO;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Receive FSM: assembles bits into sr and hands complete words to COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sr    <= {WIDTH{1'b0}};
      cnt   <= CNT_ZERO;
      order <= ORDER_MSB_FIRST;
    end else begin
      case (state)
        S_IDLE: begin
          sr  <= {WIDTH{1'b0}};
          cnt <= CNT_ZERO;
          if (frame_sync) begin
            state <= S_SHIFT;
            order <= bit_order_e'(lsb_first_i);
          end
        end
        S_SHIFT: begin
          if (!frame_sync) begin
            state <= S_IDLE;
            sr    <= {WIDTH{1'b0}};
            cnt   <= CNT_ZERO;
          end else if (shift) begin
            sr  <= shift_in(sr, data_sync, order);
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state <= S_COMMIT;
            end
          end else if (tmo_hit) begin
            sr  <= {WIDTH{1'b0}};
            cnt <= CNT_ZERO;
          end
        end
        S_COMMIT: begin
          // A new word starts here, so the bit order is sampled again.
          order <= bit_order_e'(lsb_first_i);
          if (frame_sync) begin
            state <= S_SHIFT;
            if (shift) begin
              sr  <= shift_in(sr, data_sync, bit_order_e'(lsb_first_i));
              cnt <= CNT_ONE;
            end else begin
              cnt <= CNT_ZERO;
            end
          end else begin
            state <= S_IDLE;
            sr    <= {WIDTH{1'b0}};
            cnt   <= CNT_ZERO;
          end
        end
        default: begin
          state <= S_IDLE;
          sr    <= {WIDTH{1'b0}};
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign commit    = (state == S_COMMIT);
  assign load      = commit && (!valid_o || ready_i);
  assign bit_cnt_o = cnt;

  // One-deep output register, overrun flag and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o    <= {WIDTH{1'b0}};
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (load) begin
        data_o  <= sr;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (clear_i) begin
        overrun_o <= 1'b0;
      end else if (commit && !load) begin
        overrun_o <= 1'b1;
      end
      timeout_o <= tmo_hit;
    end
  end

endmodule
